inst_encoder: RTL and testbench

Pipelined RV32I instruction encoder: the inverse of the instruction decoder. Accepts decoded-instruction records (opcode, register addresses, funct fields, sign-extended immediate, PC) over a valid/ready handshake and emits packed 32-bit instruction words. Used by the self-test instruction generator and the trace-replay path to feed the fetch stage. Flags unencodable records instead of silently truncating them.

---
 rtl/inst_encoder_pkg.sv | 41 ++++
 rtl/inst_encoder_pack.sv | 76 +++++++
 rtl/inst_encoder.sv | 75 +++++++
 tb/tb_inst_encoder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoder types: opcode enumeration, decoded-instruction record and constants.
package inst_encoder_pkg;

    localparam int unsigned cXLEN = 32;
    localparam int unsigned cCntW = 16;
    localparam logic [cXLEN-1:0] cNopInst = 32'h0000_0013;

    typedef enum logic [6:0] {
        Load    = 7'b0000011,
        Fence   = 7'b0001111,
        Immedi  = 7'b0010011,
        AuIpc   = 7'b0010111,
        Store   = 7'b0100011,
        Reg     = 7'b0110011,
        Lui     = 7'b0110111,
        Branch  = 7'b1100011,
        Jalr    = 7'b1100111,
        Jal     = 7'b1101111,
        CntrlSt = 7'b1110011
    } tOpcodeEnum;

    // Opcode is kept raw so records carrying non-RV32I opcodes can be flagged.
    typedef struct packed {
        logic [6:0]       opcode;
        logic [4:0]       rdAddr;
        logic [4:0]       rs1Addr;
        logic [4:0]       rs2Addr;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [cXLEN-1:0] imm;
        logic [cXLEN-1:0] curPc;
    } tDecodedInst;

    // True when bits [cXLEN-1:msb] of v are all copies of one value.
    function automatic logic sextFits(input logic [cXLEN-1:0] v, input int unsigned msb);
        logic signed [cXLEN-1:0] sh;
        sh = $signed(v) >>> msb;
        return (sh == '0) || (sh == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational packer: decoded record to 32-bit RV32I word plus an unencodable flag.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  tDecodedInst      iRec,
    output logic [cXLEN-1:0] oWord,
    output logic             oIllegal
);

    logic [6:0]       op;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [cXLEN-1:0] imm;
    logic [cXLEN-1:0] iForm;
    logic [cXLEN-1:0] word;
    logic             bad;
    logic             unusedPc;

    assign op       = iRec.opcode;
    assign rd       = iRec.rdAddr;
    assign rs1      = iRec.rs1Addr;
    assign rs2      = iRec.rs2Addr;
    assign f3       = iRec.funct3;
    assign f7       = iRec.funct7;
    assign imm      = iRec.imm;
    assign iForm    = {imm[11:0], rs1, f3, rd, op};
    assign unusedPc = ^iRec.curPc;

    always_comb begin
        word = '0;
        bad  = 1'b0;
        case (op)
            Reg: begin
                word = {f7, rs2, rs1, f3, rd, op};
                bad  = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            Immedi: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // Shift-immediates: upper immediate bits come from funct7.
                    word = {f7, imm[4:0], rs1, f3, rd, op};
                    bad  = (f3 == 3'b001) ? (f7 != 7'h00) : !(f7 == 7'h00 || f7 == 7'h20);
                end else begin
                    word = iForm;
                    bad  = !sextFits(imm, 11);
                end
            end
            Load, Jalr, Fence, CntrlSt: begin
                word = iForm;
                bad  = !sextFits(imm, 11);
            end
            Store: begin
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                bad  = !sextFits(imm, 11);
            end
            Branch: begin
                word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                bad  = !sextFits(imm, 12) || imm[0];
            end
            Lui, AuIpc: begin
                word = {imm[31:12], rd, op};
                bad  = (imm[11:0] != 12'h000);
            end
            Jal: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                bad  = !sextFits(imm, 20) || imm[0];
            end
            default: bad = 1'b1;
        endcase
        oWord    = bad ? cNopInst : word;
        oIllegal = bad;
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder with valid/ready handshakes and output statistics.
module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic             iClk,
    input  logic             iRst,
    input  tDecodedInst      iDecoded,
    input  logic             iValid,
    output logic             oReady,
    output logic [cXLEN-1:0] oInst,
    output logic [cXLEN-1:0] oPc,
    output logic             oIllegal,
    output logic             oValid,
    input  logic             iReady,
    output logic [cCntW-1:0] oEncCount,
    output logic [cCntW-1:0] oIllCount
);

    logic             s1Valid;
    tDecodedInst      s1Rec;
    logic             adv;
    logic [cXLEN-1:0] packWord;
    logic             packIllegal;

    // iReady reaches oReady combinationally; iValid never does.
    assign adv    = !oValid || iReady;
    assign oReady = !s1Valid || adv;

    inst_pack uPack (
        .iRec     (s1Rec),
        .oWord    (packWord),
        .oIllegal (packIllegal)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1Valid <= 1'b0;
            s1Rec   <= '0;
        end else if (oReady) begin
            s1Valid <= iValid;
            if (iValid) begin
                s1Rec <= iDecoded;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oValid   <= 1'b0;
            oInst    <= '0;
            oPc      <= '0;
            oIllegal <= 1'b0;
        end else if (adv) begin
            oValid <= s1Valid;
            if (s1Valid) begin
                oInst    <= packWord;
                oPc      <= s1Rec.curPc;
                oIllegal <= packIllegal;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oEncCount <= '0;
            oIllCount <= '0;
        end else if (oValid && iReady) begin
            oEncCount <= oEncCount + cCntW'(1);
            if (oIllegal) begin
                oIllCount <= oIllCount + cCntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomised bench for inst_encoder: encodings are decoded back and compared with the sent records.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic             iClk = 1'b0;
    logic             iRst;
    tDecodedInst      iDecoded;
    logic             iValid;
    logic             oReady;
    logic [cXLEN-1:0] oInst;
    logic [cXLEN-1:0] oPc;
    logic             oIllegal;
    logic             oValid;
    logic             iReady;
    logic [cCntW-1:0] oEncCount;
    logic [cCntW-1:0] oIllCount;

    inst_encoder dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iDecoded  (iDecoded),
        .iValid    (iValid),
        .oReady    (oReady),
        .oInst     (oInst),
        .oPc       (oPc),
        .oIllegal  (oIllegal),
        .oValid    (oValid),
        .iReady    (iReady),
        .oEncCount (oEncCount),
        .oIllCount (oIllCount)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        tDecodedInst rec;
        logic [31:0] golden;
        logic        hasG;
    } tSbEntry;

    tSbEntry     sbQ[$];
    int          nChecks = 0;
    int          nErrors = 0;
    logic [15:0] encModel = '0;
    logic [15:0] illModel = '0;
    tDecodedInst cur;
    logic [31:0] curGolden;
    logic        curHasG;
    logic        ovSeen;
    logic        stallPrev = 1'b0;
    logic [64:0] stallSnap;
    tOpcodeEnum  opList[11] = '{Load, Fence, Immedi, AuIpc, Store, Reg, Lui, Branch, Jalr, Jal,
                                CntrlSt};

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic tDecodedInst mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] imm);
        tDecodedInst r;
        r.opcode = op; r.rdAddr = rd; r.rs1Addr = rs1; r.rs2Addr = rs2;
        r.funct3 = f3; r.funct7 = f7; r.imm = imm; r.curPc = $urandom & 32'hFFFF_FFFC;
        return r;
    endfunction

    // Encodability judged from the numeric range each format can represent.
    function automatic bit isLegal(input tDecodedInst r);
        int s;
        s = $signed(r.imm);
        case (r.opcode)
            Reg: return r.funct7 == 7'h00 ||
                        (r.funct7 == 7'h20 && (r.funct3 == 3'd0 || r.funct3 == 3'd5));
            Immedi: begin
                if (r.funct3 == 3'd1) return r.funct7 == 7'h00;
                if (r.funct3 == 3'd5) return r.funct7 == 7'h00 || r.funct7 == 7'h20;
                return s >= -2048 && s <= 2047;
            end
            Load, Jalr, Fence, CntrlSt, Store: return s >= -2048 && s <= 2047;
            Branch: return s >= -4096 && s <= 4095 && (s % 2) == 0;
            Jal: return s >= -(1 << 20) && s <= (1 << 20) - 1 && (s % 2) == 0;
            Lui, AuIpc: return (r.imm % 4096) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Keep only the fields that the opcode's format carries.
    function automatic tDecodedInst canon(input tDecodedInst r);
        tDecodedInst c;
        c = '0;
        c.opcode = r.opcode;
        case (r.opcode)
            Reg: begin
                c.rdAddr = r.rdAddr; c.rs1Addr = r.rs1Addr; c.rs2Addr = r.rs2Addr;
                c.funct3 = r.funct3; c.funct7 = r.funct7;
            end
            Load, Immedi, Jalr, Fence, CntrlSt: begin
                c.rdAddr = r.rdAddr; c.rs1Addr = r.rs1Addr; c.funct3 = r.funct3;
                if (r.opcode == Immedi && (r.funct3 == 3'd1 || r.funct3 == 3'd5)) begin
                    c.funct7 = r.funct7; c.imm = r.imm % 32;
                end else begin
                    c.imm = r.imm;
                end
            end
            Store, Branch: begin
                c.rs1Addr = r.rs1Addr; c.rs2Addr = r.rs2Addr; c.funct3 = r.funct3; c.imm = r.imm;
            end
            default: begin
                c.rdAddr = r.rdAddr; c.imm = r.imm;
            end
        endcase
        return c;
    endfunction

    // Instruction decoder: recovers the canonical record from a packed word.
    function automatic tDecodedInst decodeWord(input logic [31:0] w);
        tDecodedInst c;
        c = '0;
        c.opcode = w[6:0];
        case (w[6:0])
            Reg: begin
                c.rdAddr = w[11:7]; c.rs1Addr = w[19:15]; c.rs2Addr = w[24:20];
                c.funct3 = w[14:12]; c.funct7 = w[31:25];
            end
            Load, Immedi, Jalr, Fence, CntrlSt: begin
                c.rdAddr = w[11:7]; c.rs1Addr = w[19:15]; c.funct3 = w[14:12];
                if (w[6:0] == Immedi && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) begin
                    c.funct7 = w[31:25]; c.imm = {27'd0, w[24:20]};
                end else begin
                    c.imm = {{20{w[31]}}, w[31:20]};
                end
            end
            Store: begin
                c.rs1Addr = w[19:15]; c.rs2Addr = w[24:20]; c.funct3 = w[14:12];
                c.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            Branch: begin
                c.rs1Addr = w[19:15]; c.rs2Addr = w[24:20]; c.funct3 = w[14:12];
                c.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            Lui, AuIpc: begin
                c.rdAddr = w[11:7]; c.imm = {w[31:12], 12'd0};
            end
            default: begin
                c.rdAddr = w[11:7];
                c.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
        endcase
        return c;
    endfunction

    function automatic tDecodedInst gen();
        tDecodedInst r;
        r.opcode  = opList[$urandom_range(0, 10)];
        if ($urandom_range(0, 15) == 0) r.opcode = 7'($urandom_range(0, 127));
        r.rdAddr  = 5'($urandom);
        r.rs1Addr = 5'($urandom);
        r.rs2Addr = 5'($urandom);
        r.funct3  = 3'($urandom);
        r.funct7  = ($urandom_range(0, 7) == 0) ? 7'($urandom)
                  : ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00);
        case (r.opcode)
            Branch:     r.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            Jal:        r.imm = 32'((int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
            Lui, AuIpc: r.imm = $urandom & 32'hFFFF_F000;
            default:    r.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        endcase
        if ($urandom_range(0, 9) == 0) r.imm = $urandom;
        r.curPc = $urandom;
        return r;
    endfunction

    task automatic popCheck();
        tSbEntry e;
        bit      legal;
        e = sbQ.pop_front();
        legal = isLegal(e.rec);
        checkVal("pc", oPc, e.rec.curPc);
        checkVal("illegalFlag", oIllegal, !legal);
        if (legal) checkVal("roundTrip", decodeWord(oInst), canon(e.rec));
        else       checkVal("nopWord", oInst, 32'h0000_0013);
        if (e.hasG) checkVal("golden", oInst, e.golden);
        checkVal("encCount", oEncCount, encModel);
        checkVal("illCount", oIllCount, illModel);
        encModel++;
        if (!legal) illModel++;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later.
    task automatic step(input logic v, input logic rdy, output logic acc);
        @(negedge iClk);
        iValid = v; iDecoded = cur; iReady = rdy;
        #1;
        checkVal("oReady", oReady, !(sbQ.size() == 2 && !rdy));
        if (stallPrev) checkVal("stallHold", {oInst, oPc, oIllegal}, stallSnap);
        stallPrev = oValid && !rdy;
        stallSnap = {oInst, oPc, oIllegal};
        ovSeen = oValid;
        if (oValid && rdy) begin
            if (sbQ.size() == 0) checkVal("spuriousOut", 1'b1, 1'b0);
            else popCheck();
        end
        acc = v && oReady;
        if (acc) sbQ.push_back('{rec: cur, golden: curGolden, hasG: curHasG});
    endtask

    task automatic sendDir(input tDecodedInst r, input logic [31:0] golden);
        logic acc;
        int   n;
        cur = r; curGolden = golden; curHasG = 1'b1;
        n = 0;
        do begin
            step(1'b1, 1'b1, acc);
            n++;
        end while (!acc && n < 20);
        checkVal("dirAccept", acc, 1'b1);
        curHasG = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (sbQ.size() > 0 && n < 20) begin
            step(1'b0, 1'b1, acc);
            n++;
        end
        checkVal("drainEmpty", sbQ.size(), 0);
        step(1'b0, 1'b1, acc);
        checkVal("drainEncCount", oEncCount, encModel);
        checkVal("drainIllCount", oIllCount, illModel);
    endtask

    task automatic doReset();
        @(negedge iClk);
        iRst = 1'b1; iValid = 1'b0;
        #1;
        checkVal("rstValid", oValid, 1'b0);
        checkVal("rstReady", oReady, 1'b1);
        checkVal("rstCounts", {oEncCount, oIllCount}, 32'd0);
        checkVal("rstOut", {oInst, oPc, oIllegal}, 65'd0);
        sbQ.delete();
        encModel = '0; illModel = '0; stallPrev = 1'b0;
        @(negedge iClk);
        iRst = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   n;
        int   c;
        iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iDecoded = '0;
        cur = '0; curGolden = '0; curHasG = 1'b0; ovSeen = 1'b0;
        #12;
        checkVal("initValid", oValid, 1'b0);
        checkVal("initReady", oReady, 1'b1);
        checkVal("initOut", {oInst, oPc, oIllegal}, 65'd0);
        checkVal("initCounts", {oEncCount, oIllCount}, 32'd0);
        @(negedge iClk);
        iRst = 1'b0;

        sendDir(mk(Immedi, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5), 32'h0050_0093);
        sendDir(mk(Reg, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0), 32'h4020_81B3);
        sendDir(mk(Store, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8), 32'h0020_A423);
        sendDir(mk(Branch, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, -32'sd4), 32'hFE20_8EE3);
        sendDir(mk(Jal, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8), 32'h0080_00EF);
        sendDir(mk(Lui, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000), 32'h1234_52B7);
        sendDir(mk(Immedi, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h800), 32'h0000_0013);
        sendDir(mk(Branch, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3), 32'h0000_0013);
        sendDir(mk(Lui, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001), 32'h0000_0013);
        drain();
        checkVal("dirEncTotal", oEncCount, 16'd9);
        checkVal("dirIllTotal", oIllCount, 16'd3);

        // Fill both stages against a stalled output, then reset mid-stall.
        cur = gen(); step(1'b1, 1'b0, acc);
        cur = gen(); step(1'b1, 1'b0, acc);
        cur = gen(); step(1'b1, 1'b0, acc);
        checkVal("fullStall", acc, 1'b0);
        doReset();

        // Presented in cycle 0, captured, visible on oValid two edges later.
        cur = mk(Immedi, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
        curGolden = 32'h0050_0093; curHasG = 1'b1;
        step(1'b1, 1'b1, acc);
        curHasG = 1'b0;
        checkVal("latAccept", acc, 1'b1);
        step(1'b0, 1'b1, acc);
        checkVal("latEdge1", ovSeen, 1'b0);
        step(1'b0, 1'b1, acc);
        checkVal("latEdge2", ovSeen, 1'b1);
        drain();

        doReset();
        n = 0; c = 0;
        cur = gen();
        while (n < 8 && c < 100) begin
            step(1'b1, (c % 4 == 0) || (c % 4 == 3), acc);
            if (acc) begin
                n++;
                cur = gen();
            end
            c++;
        end
        checkVal("b2bAccepted", n, 8);
        drain();
        checkVal("b2bEncCount", oEncCount, 16'd8);

        n = 0; c = 0;
        cur = gen();
        while (n < 1000 && c < 20000) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, acc);
            if (acc) begin
                n++;
                cur = gen();
            end
            c++;
        end
        checkVal("randAccepted", n, 1000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
